// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
// A request issues on ireq && igrant; responses return in issue order.
interface inst_fetch_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic        igrant;
  logic        irvalid;
  logic [31:0] irdata;

  modport master (output ireq, output iaddr, input igrant, input irvalid, input irdata);
  modport slave  (input ireq, input iaddr, output igrant, output irvalid, output irdata);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: in-order requests to instruction memory and a 2-entry
// {inst, addr} buffer towards decode, with redirect flush and stale-response drop.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master mem,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_addr,
  output logic         if_valid,
  output logic [31:0]  if_inst,
  output logic [31:0]  if_cur_instaddress,
  output logic [31:0]  if_next_instaddress
);
  typedef enum logic {ST_HOLD, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [31:0] fetch_pc, resp_pc;
  logic [1:0]  outstanding, stale, count;
  logic        rd_ptr, wr_ptr;
  logic [31:0] buf_inst [DEPTH];
  logic [31:0] buf_addr [DEPTH];
  logic        req, issue, resp, drop, push, pop;
  logic [2:0]  occupancy;

  function automatic logic [31:0] word_after(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // Outstanding requests count against buffer space so a response always has a slot.
  assign occupancy = {1'b0, outstanding} + {1'b0, count};

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      ST_HOLD: state_nxt = ST_RUN;
      ST_RUN:  req = (occupancy < 3'd2) && !redirect;
      default: state_nxt = ST_HOLD;
    endcase
  end

  assign mem.ireq  = req;
  assign mem.iaddr = fetch_pc;
  assign issue     = req && mem.igrant;
  assign resp      = mem.irvalid && (outstanding != 2'd0);
  assign drop      = resp && (redirect || (stale != 2'd0));
  assign push      = resp && !drop;
  assign pop       = if_valid && !stall && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HOLD;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      stale       <= 2'd0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding + {1'b0, issue} - {1'b0, resp};
      if (redirect) begin
        // Everything still in flight belongs to the old path and must be dropped.
        fetch_pc <= redirect_addr;
        resp_pc  <= redirect_addr;
        stale    <= outstanding - {1'b0, resp};
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end else begin
        if (issue) fetch_pc <= word_after(fetch_pc);
        if (drop)  stale    <= stale - 2'd1;
        if (push) begin
          resp_pc <= word_after(resp_pc);
          wr_ptr  <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= mem.irdata;
      buf_addr[wr_ptr] <= resp_pc;
    end
  end

  // Outputs read as zero whenever the buffer is empty, including during reset.
  assign if_valid            = (count != 2'd0);
  assign if_inst             = if_valid ? buf_inst[rd_ptr] : 32'd0;
  assign if_cur_instaddress  = if_valid ? buf_addr[rd_ptr] : 32'd0;
  assign if_next_instaddress = if_valid ? word_after(buf_addr[rd_ptr]) : 32'd0;
endmodule
